// File: rtl/seg_scan_disp.sv
// Multiplexed hex display scanner: frame-synchronous data commit,
// leading-zero blanking and PWM brightness on the digit enables.
module seg_scan_disp #(
  parameter int DIGITS     = 6,
  parameter int DISP_WIDTH = 7,
  parameter int PRESCALE   = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  output logic [DISP_WIDTH-1:0] seg_out,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = CW + 5;
  localparam int DW = 4 * DIGITS;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [BW-1:0] PS_W     = BW'(PRESCALE);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic                  pend_q, pend_d;
  logic [DISP_WIDTH-1:0] seg_q, seg_d;
  logic [DIGITS-1:0]     dig_q, dig_d;
  logic                  fd_q, fd_d;

  logic                  wrap;
  logic                  last;
  logic [3:0]            nib;
  logic                  zacc;
  logic                  blank;
  logic [6:0]            seg7;
  logic [BW-1:0]         lhs;
  logic [BW-1:0]         rhs;
  logic                  lit;

  always_comb begin
    wrap     = (cnt_q == CNT_LAST);
    last     = wrap && (idx_q == IDX_LAST);
    cnt_d    = wrap ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    shadow_d = load ? data_in : shadow_q;
    // a load on the commit edge re-arms pending for the next frame
    pend_d   = load ? 1'b1 : (last ? 1'b0 : pend_q);
    disp_d   = (last && pend_q) ? shadow_q : disp_q;
  end

  always_comb begin
    nib   = '0;
    blank = 1'b0;
    zacc  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      zacc = zacc & (disp_q[4*(DIGITS-1-i) +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        nib   = disp_q[4*(DIGITS-1-i) +: 4];
        blank = blank_lz & zacc & (i != DIGITS - 1);
      end
    end
  end

  always_comb begin
    seg7 = '0;
    unique case (nib)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      4'hF: seg7 = 7'h71;
    endcase
  end

  always_comb begin
    lhs   = {1'b0, cnt_q, 4'b0000};
    rhs   = (BW'(bright) + BW'(1)) * PS_W;
    lit   = (lhs < rhs);
    seg_d = blank ? '0 : DISP_WIDTH'(seg7);
    dig_d = lit ? (DIGITS'(1) << idx_q) : '0;
    fd_d  = last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      seg_q    <= '0;
      dig_q    <= '0;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      fd_q     <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_en     = dig_q;
  assign frame_done = fd_q;

endmodule
